// File: rtl/pid_pkg.sv
// Shared widths, saturation ranges and types for the pid_ctrl pipeline.
// Optional derivative path is selected by PID_DTERM_EN (see pid_ctrl.sv).
package pid_pkg;

  localparam int ERR_IN_W  = 16;
  localparam int ERR_W     = 10;
  localparam int DDIFF_W   = 11;
  localparam int DSAT_W    = 8;
  localparam int DTERM_W   = 13;
  localparam int PTERM_W   = 14;
  localparam int INTEG_W   = 16;
  localparam int PIDSUM_W  = 16;
  localparam int PID_W     = 12;
  localparam int SPD_W     = 12;
  localparam int SPDCALC_W = 14;

  localparam int ERR_MAX   = 511;
  localparam int ERR_MIN   = -512;
  localparam int DSAT_MAX  = 127;
  localparam int DSAT_MIN  = -128;
  localparam int INTEG_MAX = 32767;
  localparam int INTEG_MIN = -32768;
  localparam int PID_MAX   = 2047;
  localparam int PID_MIN   = -2048;
  localparam int SPD_MAX   = 4095;

  typedef logic signed [ERR_W-1:0] err_sat_t;
  typedef logic signed [PID_W-1:0] pid_t;
  typedef logic        [SPD_W-1:0] spd_t;

  // Clamp a signed speed sum to [0, SPD_MAX]; the sum never exceeds 13 magnitude bits.
  function automatic spd_t clip_spd(input logic signed [SPDCALC_W-1:0] v);
    if (v[SPDCALC_W-1])
      return '0;
    else if (v[SPDCALC_W-2])
      return '1;
    else
      return v[SPD_W-1:0];
  endfunction

endpackage

// File: rtl/pid_sat.sv
// Signed width-reduction saturator: clamps IN_W-bit input to the OUT_W-bit signed range.
module pid_sat #(
  parameter int IN_W  = 17,
  parameter int OUT_W = 16
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout
);

  logic [IN_W-OUT_W:0] top_bits;
  logic                fits;

  // The value fits when every bit above the output sign bit matches it.
  always_comb begin
    top_bits = din[IN_W-1:OUT_W-1];
    fits     = (&top_bits) | ~(|top_bits);
    if (fits)
      dout = din[OUT_W-1:0];
    else if (din[IN_W-1])
      dout = {1'b1, {(OUT_W-1){1'b0}}};
    else
      dout = {1'b0, {(OUT_W-1){1'b1}}};
  end

endmodule

// File: rtl/pid_ctrl.sv
// Three-stage PID pipeline turning line error into left/right motor speeds.
// Define PID_DTERM_EN to build the derivative term and its prev_err register.
module pid_ctrl
  import pid_pkg::*;
#(
  parameter logic [3:0]  P_COEFF   = 4'd3,
  parameter logic [4:0]  D_COEFF   = 5'd6,
  parameter logic [11:0] FRWRD_INC = 12'd16,
  parameter logic [11:0] MAX_FRWRD = 12'h300
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       go,
  input  logic signed [ERR_IN_W-1:0] error,
  input  logic                       err_vld,
  output logic [SPD_W-1:0]           lft_spd,
  output logic [SPD_W-1:0]           rght_spd,
  output logic                       spd_vld
);

  logic accept;
  assign accept = err_vld & go;

  err_sat_t err_sat;
  pid_sat #(.IN_W(ERR_IN_W), .OUT_W(ERR_W)) u_err_sat (.din(error), .dout(err_sat));

  // Stage 1 datapath: proportional product, integrator sum, forward ramp.
  logic signed [PTERM_W-1:0] p_err_ext, p_coeff_ext, p_prod;
  logic signed [INTEG_W:0]   integ_sum;
  logic signed [INTEG_W-1:0] integ_sat;
  logic        [SPD_W:0]     frwrd_sum;
  spd_t                      frwrd_next;

  logic signed [PTERM_W-1:0] p_term_d, p_term_q;
  logic signed [INTEG_W-1:0] integ_d, integ_q;
  spd_t                      frwrd_d, frwrd_q;
  logic                      s1_vld_d, s1_vld_q;

  always_comb begin
    p_err_ext   = {{(PTERM_W-ERR_W){err_sat[ERR_W-1]}}, err_sat};
    p_coeff_ext = {{(PTERM_W-4){1'b0}}, P_COEFF};
    p_prod      = p_err_ext * p_coeff_ext;
    integ_sum   = {{(INTEG_W+1-ERR_W){err_sat[ERR_W-1]}}, err_sat}
                + {integ_q[INTEG_W-1], integ_q};
    frwrd_sum   = {1'b0, frwrd_q} + {1'b0, FRWRD_INC};
    frwrd_next  = (frwrd_sum > {1'b0, MAX_FRWRD}) ? MAX_FRWRD : frwrd_sum[SPD_W-1:0];
  end

  pid_sat #(.IN_W(INTEG_W+1), .OUT_W(INTEG_W)) u_integ_sat (.din(integ_sum), .dout(integ_sat));

  logic signed [DTERM_W-1:0] d_term;

`ifdef PID_DTERM_EN
  err_sat_t                  prev_err_d, prev_err_q;
  logic signed [DDIFF_W-1:0] d_diff;
  logic signed [DSAT_W-1:0]  d_diff_sat;
  logic signed [DTERM_W-1:0] d_ext, d_coeff_ext, d_prod;
  logic signed [DTERM_W-1:0] d_term_d, d_term_q;

  always_comb begin
    d_diff      = {err_sat[ERR_W-1], err_sat} - {prev_err_q[ERR_W-1], prev_err_q};
    d_ext       = {{(DTERM_W-DSAT_W){d_diff_sat[DSAT_W-1]}}, d_diff_sat};
    d_coeff_ext = {{(DTERM_W-5){1'b0}}, D_COEFF};
    d_prod      = d_ext * d_coeff_ext;
  end

  pid_sat #(.IN_W(DDIFF_W), .OUT_W(DSAT_W)) u_dsat (.din(d_diff), .dout(d_diff_sat));

  always_comb begin
    prev_err_d = prev_err_q;
    d_term_d   = d_term_q;
    if (!go) begin
      prev_err_d = '0;
      d_term_d   = '0;
    end else if (accept) begin
      prev_err_d = err_sat;
      d_term_d   = d_prod;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_err_q <= '0;
      d_term_q   <= '0;
    end else begin
      prev_err_q <= prev_err_d;
      d_term_q   <= d_term_d;
    end
  end

  assign d_term = d_term_q;
`else
  logic unused_d_coeff;
  assign unused_d_coeff = ^D_COEFF;
  assign d_term = '0;
`endif

  // Stage 2: sum P, floor-shifted I and D terms, then clamp to the pid range.
  logic signed [PIDSUM_W-1:0] i_term, pid_sum;
  pid_t                       pid_clamped;

  always_comb begin
    i_term  = integ_q >>> 4;
    pid_sum = {{(PIDSUM_W-PTERM_W){p_term_q[PTERM_W-1]}}, p_term_q}
            + i_term
            + {{(PIDSUM_W-DTERM_W){d_term[DTERM_W-1]}}, d_term};
  end

  pid_sat #(.IN_W(PIDSUM_W), .OUT_W(PID_W)) u_pid_sat (.din(pid_sum), .dout(pid_clamped));

  pid_t pid_d, pid_q;
  spd_t frwrd2_d, frwrd2_q;
  logic s2_vld_d, s2_vld_q;

  logic signed [SPDCALC_W-1:0] lft_calc, rght_calc;
  spd_t lft_spd_d, lft_spd_q, rght_spd_d, rght_spd_q;
  logic spd_vld_d, spd_vld_q;

  always_comb begin
    lft_calc  = {{(SPDCALC_W-SPD_W){1'b0}}, frwrd2_q} + {{(SPDCALC_W-PID_W){pid_q[PID_W-1]}}, pid_q};
    rght_calc = {{(SPDCALC_W-SPD_W){1'b0}}, frwrd2_q} - {{(SPDCALC_W-PID_W){pid_q[PID_W-1]}}, pid_q};
  end

  // Each stage loads only behind its valid; go low flushes the whole pipe.
  always_comb begin
    s1_vld_d   = accept;
    s2_vld_d   = s1_vld_q;
    spd_vld_d  = s2_vld_q;
    p_term_d   = p_term_q;
    integ_d    = integ_q;
    frwrd_d    = frwrd_q;
    pid_d      = pid_q;
    frwrd2_d   = frwrd2_q;
    lft_spd_d  = lft_spd_q;
    rght_spd_d = rght_spd_q;
    if (accept) begin
      p_term_d = p_prod;
      integ_d  = integ_sat;
      frwrd_d  = frwrd_next;
    end
    if (s1_vld_q) begin
      pid_d    = pid_clamped;
      frwrd2_d = frwrd_q;
    end
    if (s2_vld_q) begin
      lft_spd_d  = clip_spd(lft_calc);
      rght_spd_d = clip_spd(rght_calc);
    end
    if (!go) begin
      s1_vld_d   = 1'b0;
      s2_vld_d   = 1'b0;
      spd_vld_d  = 1'b0;
      p_term_d   = '0;
      integ_d    = '0;
      frwrd_d    = '0;
      pid_d      = '0;
      frwrd2_d   = '0;
      lft_spd_d  = '0;
      rght_spd_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q   <= 1'b0;
      s2_vld_q   <= 1'b0;
      spd_vld_q  <= 1'b0;
      p_term_q   <= '0;
      integ_q    <= '0;
      frwrd_q    <= '0;
      pid_q      <= '0;
      frwrd2_q   <= '0;
      lft_spd_q  <= '0;
      rght_spd_q <= '0;
    end else begin
      s1_vld_q   <= s1_vld_d;
      s2_vld_q   <= s2_vld_d;
      spd_vld_q  <= spd_vld_d;
      p_term_q   <= p_term_d;
      integ_q    <= integ_d;
      frwrd_q    <= frwrd_d;
      pid_q      <= pid_d;
      frwrd2_q   <= frwrd2_d;
      lft_spd_q  <= lft_spd_d;
      rght_spd_q <= rght_spd_d;
    end
  end

  assign lft_spd  = lft_spd_q;
  assign rght_spd = rght_spd_q;
  assign spd_vld  = spd_vld_q;

endmodule

// File: tb/tb_pid_ctrl.sv
// Directed bench for pid_ctrl; expected values are hand-computed for both PID_DTERM_EN builds.
module tb_pid_ctrl;
  import pid_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        go = 1'b0;
  logic        err_vld = 1'b0;
  logic [15:0] error = '0;
  logic [11:0] lft_spd, rght_spd;
  logic        spd_vld;

  int checks = 0;
  int failures = 0;

`ifdef PID_DTERM_EN
  localparam int E100_LFT  = 922;
  localparam int EN300_RGT = 1703;
  localparam int B1_LFT = 106, B1_RGT = 0;
  localparam int B2_LFT = 0,   B2_RGT = 273;
  localparam int B3_LFT = 203, B3_RGT = 0;
`else
  localparam int E100_LFT  = 322;
  localparam int EN300_RGT = 935;
  localparam int B1_LFT = 46, B1_RGT = 0;
  localparam int B2_LFT = 0,  B2_RGT = 93;
  localparam int B3_LFT = 59, B3_RGT = 37;
`endif

  pid_ctrl dut (
    .clk(clk),
    .rst_n(rst_n),
    .go(go),
    .error(error),
    .err_vld(err_vld),
    .lft_spd(lft_spd),
    .rght_spd(rght_spd),
    .spd_vld(spd_vld)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic signed [31:0] observed,
                             input logic signed [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs at the falling edge; returns at the next falling edge.
  task automatic applyStimulus(input logic g, input logic v, input logic [15:0] e);
    go      = g;
    err_vld = v;
    error   = e;
    @(negedge clk);
  endtask

  task automatic applyReset();
    rst_n   = 1'b0;
    go      = 1'b0;
    err_vld = 1'b0;
    error   = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    $display("[TB] start");

    // Reset state and zero-error latency
    applyReset();
    checkOutput("rst_lft", lft_spd, 0);
    checkOutput("rst_rght", rght_spd, 0);
    checkOutput("rst_vld", spd_vld, 0);
    applyStimulus(1, 1, 16'd0);
    checkOutput("zero_vld_n0", spd_vld, 0);
    applyStimulus(1, 0, 16'd0);
    checkOutput("zero_vld_n1", spd_vld, 0);
    applyStimulus(1, 0, 16'd0);
    checkOutput("zero_vld_n2", spd_vld, 1);
    checkOutput("zero_lft", lft_spd, 16);
    checkOutput("zero_rght", rght_spd, 16);
    applyStimulus(1, 0, 16'd0);
    checkOutput("zero_vld_n3", spd_vld, 0);
    checkOutput("zero_lft_hold", lft_spd, 16);

    // error = 100
    applyReset();
    applyStimulus(1, 1, 16'd100);
    applyStimulus(1, 0, 16'd0);
    applyStimulus(1, 0, 16'd0);
    checkOutput("e100_vld", spd_vld, 1);
    checkOutput("e100_lft", lft_spd, E100_LFT);
    checkOutput("e100_rght", rght_spd, 0);

    // error = -300
    applyReset();
    applyStimulus(1, 1, 16'hFED4);
    applyStimulus(1, 0, 16'd0);
    applyStimulus(1, 0, 16'd0);
    checkOutput("en300_vld", spd_vld, 1);
    checkOutput("en300_lft", lft_spd, 0);
    checkOutput("en300_rght", rght_spd, EN300_RGT);

    // Saturating error streamed for 65 cycles: integrator and ramp ceilings
    applyReset();
    for (int i = 1; i <= 65; i++) begin
      applyStimulus(1, 1, 16'h7FFF);
      if (i == 47) checkOutput("frwrd_47", dut.frwrd_q, 752);
      if (i == 48) checkOutput("frwrd_48", dut.frwrd_q, 768);
      if (i == 64) checkOutput("integ_64", dut.integ_q, 64 * ERR_MAX);
      if (i == 65) checkOutput("integ_65", dut.integ_q, INTEG_MAX);
      if (i >= 3) checkOutput("stream_vld", spd_vld, 1);
    end
    applyStimulus(1, 0, 16'd0);
    checkOutput("sat_vld_n1", spd_vld, 1);
    checkOutput("integ_hold", dut.integ_q, INTEG_MAX);
    checkOutput("frwrd_hold", dut.frwrd_q, 768);
    applyStimulus(1, 0, 16'd0);
    checkOutput("sat_vld_n2", spd_vld, 1);
    checkOutput("sat_lft", lft_spd, 2815);
    checkOutput("sat_rght", rght_spd, 0);
    applyStimulus(1, 0, 16'd0);
    checkOutput("sat_vld_end", spd_vld, 0);

    // Back-to-back pulses, go dropped after the third strobe
    applyReset();
    applyStimulus(1, 1, 16'd10);
    checkOutput("b2b_vld_a", spd_vld, 0);
    applyStimulus(1, 1, 16'hFFEC);
    checkOutput("b2b_vld_b", spd_vld, 0);
    applyStimulus(1, 1, 16'd4);
    checkOutput("b2b_s1_vld", spd_vld, 1);
    checkOutput("b2b_s1_lft", lft_spd, B1_LFT);
    checkOutput("b2b_s1_rght", rght_spd, B1_RGT);
    applyStimulus(1, 1, 16'd0);
    checkOutput("b2b_s2_vld", spd_vld, 1);
    checkOutput("b2b_s2_lft", lft_spd, B2_LFT);
    checkOutput("b2b_s2_rght", rght_spd, B2_RGT);
    applyStimulus(1, 1, 16'd0);
    checkOutput("b2b_s3_vld", spd_vld, 1);
    checkOutput("b2b_s3_lft", lft_spd, B3_LFT);
    checkOutput("b2b_s3_rght", rght_spd, B3_RGT);
    applyStimulus(0, 0, 16'd0);
    checkOutput("godrop_vld", spd_vld, 0);
    checkOutput("godrop_lft", lft_spd, 0);
    checkOutput("godrop_rght", rght_spd, 0);
    checkOutput("godrop_integ", dut.integ_q, 0);
    checkOutput("godrop_frwrd", dut.frwrd_q, 0);
`ifdef PID_DTERM_EN
    checkOutput("godrop_prev", dut.prev_err_q, 0);
`endif
    applyStimulus(0, 1, 16'd50);
    checkOutput("godrop_vld2", spd_vld, 0);
    applyStimulus(0, 0, 16'd0);
    checkOutput("godrop_vld3", spd_vld, 0);

    // Asynchronous reset while a strobe is showing
    applyReset();
    applyStimulus(1, 1, 16'd100);
    applyStimulus(1, 1, 16'd100);
    applyStimulus(1, 0, 16'd0);
    checkOutput("arst_pre_vld", spd_vld, 1);
    checkOutput("arst_pre_lft", lft_spd, E100_LFT);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst_vld", spd_vld, 0);
    checkOutput("arst_lft", lft_spd, 0);
    checkOutput("arst_rght", rght_spd, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 0, 16'd0);
      checkOutput("arst_idle_vld", spd_vld, 0);
    end
    applyStimulus(1, 1, 16'd0);
    applyStimulus(1, 0, 16'd0);
    applyStimulus(1, 0, 16'd0);
    checkOutput("arst_new_vld", spd_vld, 1);
    checkOutput("arst_new_lft", lft_spd, 16);
    checkOutput("arst_new_rght", rght_spd, 16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
